// File: rtl/pili_monitor_pkg.sv
// Shared types and constants for the pili_2 wrap/flag monitor and its 7-segment display.
// Latency: n/a (declarations only).  Backpressure: n/a.
package pili_monitor_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] AN_ONES = 2'b01;
    localparam logic [1:0] AN_TENS = 2'b10;

    // Segment order is gfedcba, active-high.
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    localparam logic [6:0] SEG_RST = SEG_0;

    // Two-digit BCD increment, rolling 99 over to 00.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        bcd_t tens;
        bcd_t ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd9) begin
            if (tens == 4'd9) begin
                return 8'h00;
            end
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

endpackage

// File: rtl/pili_monitor_seg7_decode.sv
// Hex nibble to gfedcba segment pattern.
// Latency: combinational.  Backpressure: none.
module seg7_decode
    import pili_monitor_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_0;
        endcase
    end

endmodule

// File: rtl/pili_monitor.sv
// Monitors a pili_2 counter: wrap pulses, BCD wrap count, sticky flags, optional step check (PILI_MONITOR_ERRCHK_EN), 2-digit scan.
// Latency: 1 cycle from sample to Wrap/CycCnt/FlagSeen/Err.  Backpressure: none, samples every cycle.
module pili_monitor
    import pili_monitor_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic [3:0] Q,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    output logic       Wrap,
    output logic [7:0] CycCnt,
    output logic [5:0] FlagSeen,
    output logic       Err,
    output logic [3:0] ErrQ,
    output logic [6:0] Seg,
    output logic [1:0] An
);

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    logic [3:0] qd;
    logic       valid;
    logic [7:0] div;
    logic       wrap_det;
    logic       scan_edge;
    bcd_t       dig_nxt;
    logic [6:0] seg_nxt;

    assign wrap_det  = valid && (qd == 4'hF) && (Q == 4'h0);
    assign scan_edge = (div == DIV_LAST);
    // Digit for the slot about to start: the one An swaps to.
    assign dig_nxt   = (An == AN_ONES) ? CycCnt[7:4] : CycCnt[3:0];

    seg7_decode u_seg7 (
        .hex (dig_nxt),
        .seg (seg_nxt)
    );

    always_ff @(posedge Clk) begin
        if (Clr) begin
            qd       <= 4'd0;
            valid    <= 1'b0;
            Wrap     <= 1'b0;
            CycCnt   <= 8'h00;
            FlagSeen <= 6'd0;
            div      <= 8'd0;
            An       <= AN_ONES;
            Seg      <= SEG_RST;
        end else begin
            qd       <= Q;
            valid    <= 1'b1;
            Wrap     <= wrap_det;
            if (wrap_det) begin
                CycCnt <= bcd2_inc(CycCnt);
            end
            FlagSeen <= FlagSeen | {F, E, D, C, B, A};
            if (scan_edge) begin
                div <= 8'd0;
                An  <= ~An;
                Seg <= seg_nxt;
            end else begin
                div <= div + 8'd1;
            end
        end
    end

`ifdef PILI_MONITOR_ERRCHK_EN
    logic step_bad;

    assign step_bad = valid && (Q != qd) && (Q != qd + 4'd1);

    // Only the first illegal value is kept; Err gates further captures.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            Err  <= 1'b0;
            ErrQ <= 4'd0;
        end else if (step_bad && !Err) begin
            Err  <= 1'b1;
            ErrQ <= Q;
        end
    end
`else
    assign Err  = 1'b0;
    assign ErrQ = 4'd0;
`endif

endmodule

// File: tb/tb_pili_monitor.sv
// Self-checking bench for pili_monitor: vector table, directed corner sequences, randomized run vs. reference model.
module tb_pili_monitor;

    localparam int SD = 4;
`ifdef PILI_MONITOR_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Clr;
    logic [3:0] Q;
    logic       A, B, C, D, E, F;
    logic       Wrap;
    logic [7:0] CycCnt;
    logic [5:0] FlagSeen;
    logic       Err;
    logic [3:0] ErrQ;
    logic [6:0] Seg;
    logic [1:0] An;

    pili_monitor #(.SCAN_DIV(SD)) dut (
        .Clk(Clk), .Clr(Clr), .Q(Q),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F),
        .Wrap(Wrap), .CycCnt(CycCnt), .FlagSeen(FlagSeen),
        .Err(Err), .ErrQ(ErrQ), .Seg(Seg), .An(An)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int wrap_seen = 0;

    logic [6:0] segs [16];

    // Reference model state
    bit         m_valid;
    int         m_qd;
    int         m_count;
    int         m_edges;
    logic       x_wrap;
    logic [5:0] x_fs;
    logic       x_err;
    logic [3:0] x_errq;
    logic [1:0] x_an;
    logic [6:0] x_seg;

    typedef struct {
        logic       clr;
        logic [3:0] q;
        logic [5:0] f;
        logic       wrap;
        logic [7:0] cyc;
        logic [5:0] fs;
        logic       err;
        logic [3:0] errq;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_bcd();
        return 8'(((m_count / 10) << 4) | (m_count % 10));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_qd = 0; m_count = 0; m_edges = 0;
        x_wrap = 0; x_fs = 0; x_err = 0; x_errq = 0;
        x_an = 2'b01; x_seg = segs[0];
    endtask

    task automatic model_step(input logic [3:0] q_i, input logic [5:0] f_i);
        int q;
        q = int'(q_i);
        m_edges++;
        if (m_edges % SD == 0) begin
            x_an  = (x_an == 2'b01) ? 2'b10 : 2'b01;
            x_seg = (x_an == 2'b10) ? segs[m_count / 10] : segs[m_count % 10];
        end
        x_wrap = m_valid && m_qd == 15 && q == 0;
        if (x_wrap) m_count = (m_count + 1) % 100;
        if (ERRCHK && m_valid && !x_err && q != m_qd && q != (m_qd + 1) % 16) begin
            x_err  = 1'b1;
            x_errq = q_i;
        end
        x_fs    = x_fs | f_i;
        m_qd    = q;
        m_valid = 1;
    endtask

    // One clock: drive, advance the model, compare every output at the falling edge.
    task automatic cyc(input logic clr_i, input logic [3:0] q_i, input logic [5:0] f_i);
        Clr = clr_i;
        Q   = q_i;
        {F, E, D, C, B, A} = f_i;
        @(posedge Clk);
        if (clr_i) model_reset();
        else       model_step(q_i, f_i);
        @(negedge Clk);
        if (Wrap === 1'b1) wrap_seen++;
        chk("m_wrap",     32'(Wrap),     32'(x_wrap));
        chk("m_cyccnt",   32'(CycCnt),   32'(m_bcd()));
        chk("m_flagseen", 32'(FlagSeen), 32'(x_fs));
        chk("m_err",      32'(Err),      32'(x_err));
        chk("m_errq",     32'(ErrQ),     32'(x_errq));
        chk("m_an",       32'(An),       32'(x_an));
        chk("m_seg",      32'(Seg),      32'(x_seg));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 4'd0, 6'd0);
    endtask

    task automatic run_seq(input int n);
        for (int k = 0; k < n; k++) begin
            for (int v = 1; v < 16; v++) cyc(1'b0, 4'(v), 6'd0);
            cyc(1'b0, 4'd0, 6'd0);
        end
    endtask

    initial begin
        segs = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        // clr, q, flags -> wrap, cyccnt, flagseen, err, errq (err/errq only with step check)
        tbl[0] = '{1'b0, 4'd15, 6'b000000, 1'b0, 8'h00, 6'b000000, 1'b0, 4'd0};
        tbl[1] = '{1'b0, 4'd0,  6'b000100, 1'b1, 8'h01, 6'b000100, 1'b0, 4'd0};
        tbl[2] = '{1'b0, 4'd0,  6'b100000, 1'b0, 8'h01, 6'b100100, 1'b0, 4'd0};
        tbl[3] = '{1'b0, 4'd1,  6'b000000, 1'b0, 8'h01, 6'b100100, 1'b0, 4'd0};
        tbl[4] = '{1'b0, 4'd3,  6'b000000, 1'b0, 8'h01, 6'b100100, 1'b1, 4'd3};
        tbl[5] = '{1'b0, 4'd5,  6'b000000, 1'b0, 8'h01, 6'b100100, 1'b1, 4'd3};
        tbl[6] = '{1'b0, 4'd6,  6'b000000, 1'b0, 8'h01, 6'b100100, 1'b1, 4'd3};

        Clr = 1'b1; Q = 4'd0; {F, E, D, C, B, A} = 6'd0;
        model_reset();

        // Reset values
        do_reset(2);
        chk("rst_wrap", 32'(Wrap), 32'd0);
        chk("rst_cyccnt", 32'(CycCnt), 32'h00);
        chk("rst_flagseen", 32'(FlagSeen), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_errq", 32'(ErrQ), 32'd0);
        chk("rst_an", 32'(An), 32'b01);
        chk("rst_seg", 32'(Seg), 32'b0111111);

        // Vector table: first-sample skip, wrap, C then F flag pulses, error capture
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].clr, tbl[i].q, tbl[i].f);
            chk($sformatf("tbl%0d_wrap", i), 32'(Wrap), 32'(tbl[i].wrap));
            chk($sformatf("tbl%0d_cyccnt", i), 32'(CycCnt), 32'(tbl[i].cyc));
            chk($sformatf("tbl%0d_flagseen", i), 32'(FlagSeen), 32'(tbl[i].fs));
            chk($sformatf("tbl%0d_err", i), 32'(Err), 32'(tbl[i].err & ERRCHK));
            chk($sformatf("tbl%0d_errq", i), 32'(ErrQ), 32'(ERRCHK ? tbl[i].errq : 4'd0));
        end
        // Flags stay sticky until Clr
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'd6, 6'd0);
        chk("flags_held", 32'(FlagSeen), 32'b100100);

        // Step check: 3,4,7,9
        do_reset(1);
        cyc(1'b0, 4'd3, 6'd0);
        cyc(1'b0, 4'd4, 6'd0);
        chk("err_before7", 32'(Err), 32'd0);
        cyc(1'b0, 4'd7, 6'd0);
        chk("err_after7", 32'(Err), 32'(ERRCHK));
        chk("errq_after7", 32'(ErrQ), ERRCHK ? 32'd7 : 32'd0);
        cyc(1'b0, 4'd9, 6'd0);
        chk("err_after9", 32'(Err), 32'(ERRCHK));
        chk("errq_after9", 32'(ErrQ), ERRCHK ? 32'd7 : 32'd0);

        // Ten full sequences
        do_reset(2);
        wrap_seen = 0;
        cyc(1'b0, 4'd0, 6'd0);
        run_seq(10);
        chk("ten_wraps", 32'(wrap_seen), 32'd10);
        chk("ten_cyccnt", 32'(CycCnt), 32'h10);

        // Hundred sequences roll back to 00
        do_reset(1);
        wrap_seen = 0;
        cyc(1'b0, 4'd0, 6'd0);
        run_seq(100);
        chk("hundred_wraps", 32'(wrap_seen), 32'd100);
        chk("hundred_cyccnt", 32'(CycCnt), 32'h00);

        // Display scan at 0x37
        do_reset(1);
        cyc(1'b0, 4'd0, 6'd0);
        run_seq(37);
        chk("scan_cyccnt", 32'(CycCnt), 32'h37);
        for (int i = 0; i < 2 * SD; i++) cyc(1'b0, 4'd0, 6'd0);
        begin
            int toggles;
            logic [1:0] prev_an;
            toggles = 0;
            prev_an = An;
            for (int i = 0; i < 3 * SD; i++) begin
                cyc(1'b0, 4'd0, 6'd0);
                if (An !== prev_an) toggles++;
                prev_an = An;
                chk("scan_seg", 32'(Seg), (x_an == 2'b01) ? 32'b0000111 : 32'b1001111);
            end
            chk("scan_toggles", 32'(toggles), 32'd3);
        end

        // Clr on the same edge as a 15 -> 0 sample
        do_reset(1);
        cyc(1'b0, 4'd14, 6'b010001);
        cyc(1'b0, 4'd15, 6'd0);
        cyc(1'b1, 4'd0, 6'd0);
        chk("clrwrap_wrap", 32'(Wrap), 32'd0);
        chk("clrwrap_cyccnt", 32'(CycCnt), 32'h00);
        chk("clrwrap_flagseen", 32'(FlagSeen), 32'd0);
        chk("clrwrap_an", 32'(An), 32'b01);
        chk("clrwrap_seg", 32'(Seg), 32'b0111111);
        cyc(1'b0, 4'd0, 6'd0);
        chk("clrwrap_nopulse", 32'(Wrap), 32'd0);
        chk("clrwrap_cnt_after", 32'(CycCnt), 32'h00);

        // Randomized run against the model
        begin
            logic [3:0] q;
            q = 4'd0;
            for (int i = 0; i < 1500; i++) begin
                int r;
                logic [5:0] f;
                r = int'($urandom_range(0, 99));
                if (r < 10)      q = 4'($urandom_range(0, 15));
                else if (r < 55) q = q;
                else             q = q + 4'd1;
                f = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
                cyc((r < 2), q, f);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
